// File: rtl/crc_serial_ctrl_pkg.sv
// Shared definitions for the serial CRC controller: FSM encoding,
// mode encoding and the default generator configuration.
package crc_serial_ctrl_pkg;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } crc_state_t;

    // Transaction mode
    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_CHK = 1'b1;

    // Default generator: G = 1011 (x^3 + x + 1)
    localparam int           DEF_BW      = 4;
    localparam int           DEF_CRC_BW  = 3;
    localparam logic [2:0]   DEF_DIVISOR = 3'b011;

endpackage

// File: rtl/crc_serial_ctrl_step.sv
// Single polynomial-division step: conditionally XOR the generator low
// bits into the already-shifted remainder.
module crc_serial_ctrl_step #(
    parameter int CRC_BW = 3
) (
    input  logic [CRC_BW-1:0] i_rem,
    input  logic              i_sel,
    input  logic [CRC_BW-1:0] i_divisor,
    output logic [CRC_BW-1:0] o_rem
);

    // Bitwise conditional subtraction (XOR) of the divisor
    for (genvar gi = 0; gi < CRC_BW; gi++) begin : g_bit
        assign o_rem[gi] = i_rem[gi] ^ (i_sel & i_divisor[gi]);
    end

endmodule

// File: rtl/crc_serial_ctrl.sv
// Sequential CRC engine. One data word per transaction, one division step
// per clock through a single shared step slice. Encode mode returns the
// codeword {data, crc}; check mode returns {data, syndrome} and flags a
// non-zero syndrome.
module crc_serial_ctrl
    import crc_serial_ctrl_pkg::*;
#(
    parameter int                BW      = DEF_BW,
    parameter int                CRC_BW  = DEF_CRC_BW,
    parameter logic [CRC_BW-1:0] DIVISOR = DEF_DIVISOR
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_mode,
    input  logic [BW-1:0]        in_data,
    input  logic [CRC_BW-1:0]    in_crc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BW+CRC_BW-1:0] out_code,
    output logic                 out_err,
    output logic                 busy
);

    localparam int              CNT_W    = $clog2(BW + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BW - 1);

    crc_state_t                 r_state;
    crc_state_t                 w_state_next;
    logic [CRC_BW-1:0]          r_rem;
    logic [BW-1:0]              r_pend;
    logic [BW-1:0]              r_data;
    logic                       r_mode;
    logic [CNT_W-1:0]           r_cnt;
    logic [BW+CRC_BW-1:0]       r_code;
    logic                       r_err;

    logic                       w_accept;
    logic                       w_step;
    logic                       w_last;
    logic [BW+CRC_BW-1:0]       w_sr;
    logic [CRC_BW-1:0]          w_shifted;
    logic [CRC_BW-1:0]          w_rem_next;

    assign w_accept = (r_state == ST_IDLE) && in_valid && !clr;
    assign w_step   = (r_state == ST_SHIFT) && !clr;
    assign w_last   = w_step && (r_cnt == CNT_LAST);

    // Full dividend: message followed by received CRC (check) or zeros (encode)
    assign w_sr = {in_data, (in_mode == MODE_CHK) ? in_crc : {CRC_BW{1'b0}}};

    // Shift the next pending bit into the remainder; its old MSB selects the XOR
    assign w_shifted = {r_rem[CRC_BW-2:0], r_pend[BW-1]};

    crc_serial_ctrl_step #(
        .CRC_BW    (CRC_BW)
    ) u_step (
        .i_rem     (w_shifted),
        .i_sel     (r_rem[CRC_BW-1]),
        .i_divisor (DIVISOR),
        .o_rem     (w_rem_next)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; clr overrides every transition
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (in_valid)  w_state_next = ST_SHIFT;
            ST_SHIFT: if (w_last)    w_state_next = ST_DONE;
            ST_DONE:  if (out_ready) w_state_next = ST_IDLE;
            default:                 w_state_next = ST_IDLE;
        endcase
        if (clr) begin
            w_state_next = ST_IDLE;
        end
    end

    // Datapath: latch the request on accept, run one division step per SHIFT cycle,
    // and capture the result on the last step so it is stable throughout DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem  <= '0;
            r_pend <= '0;
            r_data <= '0;
            r_mode <= MODE_ENC;
            r_cnt  <= '0;
            r_code <= '0;
            r_err  <= 1'b0;
        end else if (w_accept) begin
            r_rem  <= w_sr[BW+CRC_BW-1 -: CRC_BW];
            r_pend <= w_sr[BW-1:0];
            r_data <= in_data;
            r_mode <= in_mode;
            r_cnt  <= '0;
        end else if (w_step) begin
            r_rem  <= w_rem_next;
            r_pend <= {r_pend[BW-2:0], 1'b0};
            r_cnt  <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_code <= {r_data, w_rem_next};
                r_err  <= (r_mode == MODE_CHK) && (|w_rem_next);
            end
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign out_code  = r_code;
    assign out_err   = r_err;

endmodule

// File: tb/tb_crc_serial_ctrl.sv
// Self-checking bench for crc_serial_ctrl: directed vectors, backpressure,
// abort, asynchronous reset, exhaustive encode sweep and random check traffic
// compared against a long-division reference model.
module tb_crc_serial_ctrl;

    localparam int         BW     = 4;
    localparam int         CRC_BW = 3;
    localparam logic [2:0] DIV    = 3'b011;
    localparam int         CW     = BW + CRC_BW;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clr = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              in_mode = 1'b0;
    logic [BW-1:0]     in_data = '0;
    logic [CRC_BW-1:0] in_crc = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [CW-1:0]     out_code;
    logic              out_err;
    logic              busy;

    int checks = 0;
    int errors = 0;

    crc_serial_ctrl #(
        .BW        (BW),
        .CRC_BW    (CRC_BW),
        .DIVISOR   (DIV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_data   (in_data),
        .in_crc    (in_crc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .out_err   (out_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference: remainder of ({data, crc} as a polynomial) modulo G = {1, DIV}
    function automatic logic [CRC_BW-1:0] ref_rem(input logic [BW-1:0] d, input logic [CRC_BW-1:0] c);
        logic [31:0] v;
        logic [31:0] g;
        v = 32'({d, c});
        g = 32'({1'b1, DIV});
        for (int i = CW - 1; i >= CRC_BW; i--) begin
            if (v[i]) v = v ^ (g << (i - CRC_BW));
        end
        return v[CRC_BW-1:0];
    endfunction

    // Present one request, wait for the result, then hold off out_ready for
    // 'delay' cycles before a single handshake. cyc counts the accept cycle as 0.
    task automatic run_txn(input logic m, input logic [BW-1:0] d, input logic [CRC_BW-1:0] c,
                           input int delay, output logic [CW-1:0] code, output logic err,
                           output int cyc);
        @(negedge clk);
        in_valid = 1'b1; in_mode = m; in_data = d; in_crc = c;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = BW'($urandom);
        in_crc   = CRC_BW'($urandom);
        in_mode  = 1'($urandom);
        cyc = 1;
        while (!out_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        code = out_code;
        err  = out_err;
        if (!out_valid) begin
            checks++; errors++;
            $display("FAIL txn_timeout: out_valid=%0d after %0d cycles, required 1", out_valid, cyc);
            return;
        end
        repeat (delay) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        $display("txn mode=%0d data=%b crc=%b -> code=%b err=%0d cycles=%0d", m, d, c, code, err, cyc);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, out_code, out_err, busy, in_ready} !== {1'b0, 7'd0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b code=%b err=%b busy=%b ready=%b, required 0/0/0/0/1",
                     out_valid, out_code, out_err, busy, in_ready);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_encode;
        logic [CW-1:0] code; logic err; int cyc;
        run_txn(1'b0, 4'b1101, 3'b111, 0, code, err, cyc);
        checks++;
        if (code !== 7'b1101_001 || err !== 1'b0) begin
            errors++; $display("FAIL enc_1101: got code=%b err=%b, required 1101001 0", code, err);
        end
        checks++;
        if (cyc !== BW + 1) begin
            errors++; $display("FAIL enc_latency: got %0d cycles, required %0d", cyc, BW + 1);
        end
        run_txn(1'b0, 4'b1000, 3'b000, 0, code, err, cyc);
        checks++;
        if (code !== 7'b1000_101 || err !== 1'b0) begin
            errors++; $display("FAIL enc_1000: got code=%b err=%b, required 1000101 0", code, err);
        end
        run_txn(1'b0, 4'b0000, 3'b101, 0, code, err, cyc);
        checks++;
        if (code !== 7'b0000_000 || err !== 1'b0) begin
            errors++; $display("FAIL enc_0000: got code=%b err=%b, required 0000000 0", code, err);
        end
    endtask

    task automatic test_check;
        logic [CW-1:0] code; logic err; int cyc;
        run_txn(1'b1, 4'b1101, 3'b001, 0, code, err, cyc);
        checks++;
        if (code !== 7'b1101_000 || err !== 1'b0) begin
            errors++; $display("FAIL chk_good: got code=%b err=%b, required 1101000 0", code, err);
        end
        run_txn(1'b1, 4'b1101, 3'b011, 0, code, err, cyc);
        checks++;
        if (code !== 7'b1101_010 || err !== 1'b1) begin
            errors++; $display("FAIL chk_bad: got code=%b err=%b, required 1101010 1", code, err);
        end
    endtask

    task automatic test_backpressure;
        logic [CW-1:0] held; int cyc;
        @(negedge clk);
        in_valid = 1'b1; in_mode = 1'b0; in_data = 4'b1011; in_crc = 3'b000;
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 4'b0110;   // must be ignored while busy
        cyc = 1;
        while (!out_valid && cyc < 40) begin @(posedge clk); #1; cyc++; end
        held = out_code;
        checks++;
        if (held !== {4'b1011, ref_rem(4'b1011, 3'b000)}) begin
            errors++; $display("FAIL bp_code: got %b, required %b", held, {4'b1011, ref_rem(4'b1011, 3'b000)});
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || out_code !== held || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got valid=%b code=%b ready=%b, required 1 %b 0",
                         i, out_valid, out_code, in_ready, held);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_handshake: got valid=%b ready=%b, required 0 1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL bp_single: got valid=%b busy=%b, required 0 0", out_valid, busy);
        end
        $display("txn mode=0 data=1011 crc=000 -> code=%b held 10 cycles", held);
    endtask

    task automatic test_clr;
        logic [CW-1:0] code; logic err; int cyc;
        // clr and in_valid together in IDLE: nothing accepted
        @(negedge clk);
        in_valid = 1'b1; clr = 1'b1; in_data = 4'b0101; in_mode = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0; clr = 1'b0;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL clr_idle: got busy=%b ready=%b, required 0 1", busy, in_ready);
        end
        // abort in the second SHIFT cycle
        @(negedge clk);
        in_valid = 1'b1; in_mode = 1'b0; in_data = 4'b1110;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL clr_shift: got busy=%b ready=%b valid=%b, required 0 1 0", busy, in_ready, out_valid);
        end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++; $display("FAIL clr_no_result[%0d]: got valid=%b, required 0", i, out_valid);
            end
        end
        $display("txn mode=0 data=1110 aborted by clr");
        run_txn(1'b0, 4'b1101, 3'b000, 0, code, err, cyc);
        checks++;
        if (code !== 7'b1101_001 || err !== 1'b0) begin
            errors++; $display("FAIL clr_recover: got code=%b err=%b, required 1101001 0", code, err);
        end
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        in_valid = 1'b1; in_mode = 1'b1; in_data = 4'b0111; in_crc = 3'b010;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_code, out_err, busy, in_ready} !== {1'b0, 7'd0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL async_reset: got valid=%b code=%b err=%b busy=%b ready=%b, required 0/0/0/0/1",
                     out_valid, out_code, out_err, busy, in_ready);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_release: got ready=%b busy=%b, required 1 0", in_ready, busy);
        end
    endtask

    task automatic test_sweep;
        logic [CW-1:0] code; logic err; int cyc;
        logic [BW-1:0] d;
        logic [CRC_BW-1:0] r;
        for (int i = 0; i < (1 << BW); i++) begin
            d = BW'(i);
            r = ref_rem(d, '0);
            run_txn(1'b0, d, 3'($urandom), 0, code, err, cyc);
            checks++;
            if (code !== {d, r} || err !== 1'b0 || cyc !== BW + 1) begin
                errors++; $display("FAIL sweep_enc[%0d]: got code=%b err=%b cyc=%0d, required %b 0 %0d",
                                   i, code, err, cyc, {d, r}, BW + 1);
            end
            run_txn(1'b1, d, r, 0, code, err, cyc);
            checks++;
            if (code !== {d, 3'b000} || err !== 1'b0) begin
                errors++; $display("FAIL sweep_chk[%0d]: got code=%b err=%b, required %b 0", i, code, err, {d, 3'b000});
            end
        end
    endtask

    task automatic test_random;
        logic [CW-1:0] code; logic err; int cyc;
        logic m; logic [BW-1:0] d; logic [CRC_BW-1:0] c; logic [CRC_BW-1:0] r;
        for (int i = 0; i < 40; i++) begin
            m = 1'($urandom);
            d = BW'($urandom);
            c = CRC_BW'($urandom);
            r = ref_rem(d, m ? c : 3'b000);
            run_txn(m, d, c, int'($urandom_range(0, 3)), code, err, cyc);
            checks++;
            if (code !== {d, r} || err !== (m & (|r))) begin
                errors++; $display("FAIL random[%0d]: got code=%b err=%b, required %b %b", i, code, err, {d, r}, m & (|r));
            end
        end
    endtask

    initial begin
        test_reset();
        test_encode();
        test_check();
        test_backpressure();
        test_clr();
        test_async_reset();
        test_sweep();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
